// File: rtl/sw_stream_feeder.sv
// Front end of the Smith-Waterman PE chain: loads the query into the array, streams the database
// in at the array's no-stall cadence, pads the tail through the chain and captures the final score.
module sw_stream_feeder #(
  parameter int unsigned       N_PE    = 16,
  parameter int unsigned       SYM_W   = 3,
  parameter int unsigned       SCORE_W = 16,
  parameter int unsigned       LEN_W   = 12,
  parameter logic [SYM_W-1:0]  PAD_SYM = 3'd7
) (
  input  logic               clk,
  input  logic               reset_i,
  input  logic               start,
  input  logic [LEN_W-1:0]   t_len,
  input  logic               s_valid,
  input  logic [SYM_W-1:0]   s_data,
  output logic               s_ready,
  input  logic               t_valid,
  input  logic [SYM_W-1:0]   t_data,
  output logic               t_ready,
  output logic               pe_shift_valid_s,
  output logic               pe_valid_s,
  output logic [SYM_W-1:0]   pe_s,
  output logic [SYM_W-1:0]   pe_t,
  output logic               pe_init,
  input  logic [SCORE_W-1:0] pe_max,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [SCORE_W-1:0] score
);

  localparam int unsigned QCNT_W = $clog2(N_PE + 1);
  localparam int unsigned DCNT_W = $clog2(N_PE + 3);
  localparam logic [QCNT_W-1:0] QLast = QCNT_W'(N_PE - 1);
  // Drain runs N_PE+2 cycles so the last database symbol clears the chain's max pipeline.
  localparam logic [DCNT_W-1:0] DLast = DCNT_W'(N_PE + 1);

  typedef enum logic [2:0] {StIdle, StLoadS, StStreamT, StDrain, StDone} state_e;

  state_e               state_q;
  logic [QCNT_W-1:0]    q_cnt_q;
  logic [LEN_W-1:0]     t_cnt_q;
  logic [DCNT_W-1:0]    d_cnt_q;
  logic                 shift_q;
  logic                 valid_s_q;
  logic [SYM_W-1:0]     s_q;
  logic [SYM_W-1:0]     t_q;
  logic                 init_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 err_q;
  logic [SCORE_W-1:0]   score_q;

  always_comb begin
    s_ready = (state_q == StLoadS);
    t_ready = (state_q == StStreamT);
  end

  always_ff @(posedge clk) begin
    if (!reset_i) begin
      state_q   <= StIdle;
      q_cnt_q   <= '0;
      t_cnt_q   <= '0;
      d_cnt_q   <= '0;
      shift_q   <= 1'b0;
      valid_s_q <= 1'b0;
      s_q       <= '0;
      t_q       <= '0;
      init_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      score_q   <= '0;
    end else begin
      shift_q   <= 1'b0;
      valid_s_q <= 1'b0;
      done_q    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            t_cnt_q <= t_len;
            q_cnt_q <= '0;
            d_cnt_q <= '0;
            err_q   <= 1'b0;
            score_q <= '0;
            busy_q  <= 1'b1;
            state_q <= (t_len == '0) ? StDone : StLoadS;
          end
        end
        StLoadS: begin
          if (s_valid) begin
            s_q       <= s_data;
            shift_q   <= 1'b1;
            valid_s_q <= 1'b1;
            q_cnt_q   <= q_cnt_q + 1'b1;
            if (q_cnt_q == QLast) begin
              state_q <= StStreamT;
            end
          end
        end
        StStreamT: begin
          if (t_valid) begin
            t_q     <= t_data;
            init_q  <= 1'b1;
            t_cnt_q <= t_cnt_q - 1'b1;
            if (t_cnt_q == LEN_W'(1)) begin
              state_q <= StDrain;
            end
          end else begin
            // The array cannot stall: abandon the job and flush the chain.
            err_q   <= 1'b1;
            score_q <= '0;
            init_q  <= 1'b0;
            state_q <= StDone;
          end
        end
        StDrain: begin
          t_q     <= PAD_SYM;
          init_q  <= 1'b1;
          d_cnt_q <= d_cnt_q + 1'b1;
          if (d_cnt_q == DLast) begin
            score_q <= pe_max;
            state_q <= StDone;
          end
        end
        StDone: begin
          done_q  <= 1'b1;
          init_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign pe_shift_valid_s = shift_q;
  assign pe_valid_s       = valid_s_q;
  assign pe_s             = s_q;
  assign pe_t             = t_q;
  assign pe_init          = init_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign err              = err_q;
  assign score            = score_q;

endmodule
